// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
//   Sequential radix-2 shift-and-add multiplier. It takes one WIDTH x WIDTH
//   operand pair per accepted start and returns a 2*WIDTH product with a done
//   strobe after exactly WIDTH CALC cycles.
//   Optional macro MULT_SIGNED_EN: treats operands as two's complement. The
//   magnitudes are multiplied, and the result is negated when the operand
//   signs differ.
//   Handshake: start is accepted only while busy is low, that is in IDLE. Once
//   accepted, start and in1/in2 are ignored until the IDLE cycle after done.
//   done is a one-cycle strobe, and out is valid in that same cycle. out then
//   holds its value until the next done, or until rst clears it.
//   dbg_state exposes the FSM state (0 IDLE, 1 CALC, 2 DONE).
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic [1:0]         dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
`ifdef MULT_SIGNED_EN
  // The most-negative operand has magnitude 2^(WIDTH-1), so B needs one extra bit.
  localparam int BW = WIDTH + 1;
`else
  localparam int BW = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   a_reg;
  logic [BW-1:0]   b_reg;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   load_a;
  logic [BW-1:0]   load_b;
  logic [PW-1:0]   acc_sum;
  logic [PW-1:0]   result;
  logic            last_step;
`ifdef MULT_SIGNED_EN
  logic            sign_reg;
  logic            sign_in;
  logic [WIDTH:0]  ext1;
  logic [WIDTH:0]  ext2;
  logic [WIDTH:0]  mag1;
  logic [WIDTH:0]  mag2;
`endif

  // Operand preparation: build the values loaded into A and B at accept.
  always_comb begin
`ifdef MULT_SIGNED_EN
    ext1    = {in1[WIDTH-1], in1};
    ext2    = {in2[WIDTH-1], in2};
    mag1    = ext1[WIDTH] ? (~ext1 + 1'b1) : ext1;
    mag2    = ext2[WIDTH] ? (~ext2 + 1'b1) : ext2;
    sign_in = in1[WIDTH-1] ^ in2[WIDTH-1];
    load_a  = {{(PW-WIDTH-1){1'b0}}, mag1};
    load_b  = mag2;
`else
    load_a  = {{WIDTH{1'b0}}, in1};
    load_b  = in2;
`endif
  end

  // One shift-add step, plus the product as it will appear on out.
  always_comb begin
    acc_sum   = b_reg[0] ? (acc + a_reg) : acc;
    last_step = (count == CW'(WIDTH - 1));
`ifdef MULT_SIGNED_EN
    result    = sign_reg ? (~acc_sum + 1'b1) : acc_sum;
`else
    result    = acc_sum;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> CALC -> DONE -> IDLE, with no early exit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    dbg_state = state;
  end

  // Datapath: load at accept, shift-add in CALC, publish the product on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      count    <= '0;
      out      <= '0;
`ifdef MULT_SIGNED_EN
      sign_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= load_a;
            b_reg    <= load_b;
            acc      <= '0;
            count    <= '0;
`ifdef MULT_SIGNED_EN
            sign_reg <= sign_in;
`endif
          end
        end
        CALC: begin
          acc   <= acc_sum;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          count <= count + 1'b1;
          if (last_step) out <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier
//   Directed bench for seq_shift_add_multiplier at WIDTH=4, with a WIDTH=8
//   instance for the wide corner case. A cycle-level behavioural model
//   predicts busy/done/out every cycle. Driver tasks push their expected
//   products into exp_q, and each done pulse pops one entry from it.
//   Build with +define+MULT_SIGNED_EN to exercise the signed variant.
module tb_seq_shift_add_multiplier;

  localparam int W  = 4;
  localparam int W8 = 8;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [W-1:0]    in1;
  logic [W-1:0]    in2;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  out;
  logic [1:0]      dbg_state;

  logic            start8;
  logic [W8-1:0]   in1_8;
  logic [W8-1:0]   in2_8;
  logic            busy8;
  logic            done8;
  logic [2*W8-1:0] out8;
  logic [1:0]      dbg_state8;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out(out), .dbg_state(dbg_state)
  );

  seq_shift_add_multiplier #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in1(in1_8), .in2(in2_8),
    .busy(busy8), .done(done8), .out(out8), .dbg_state(dbg_state8)
  );

  // ---------------- bookkeeping ----------------
  int             errors = 0;
  int             checks = 0;
  int             cyc    = 0;
  bit             chk_en = 1'b0;
  logic [2*W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference product computed with plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
`ifdef MULT_SIGNED_EN
    p = int'($signed(a)) * int'($signed(b));
`else
    p = int'(a) * int'(b);
`endif
    return p[2*W-1:0];
  endfunction

  // ---------------- behavioural model ----------------
  // m_left counts the remaining busy cycles. It is loaded with WIDTH+1 at
  // accept (WIDTH CALC cycles followed by one DONE cycle). The last busy
  // cycle is the done cycle, and the product appears on out from that cycle.
  int             m_left = 0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_out  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_out  <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left <= W + 1;
        m_prod <= ref_prod(in1, in2);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_out <= m_prod;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_left != 0));
      check("done", 32'(done), 32'(m_left == 1));
      check("out",  32'(out),  32'(m_out));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(1), 32'(0));
        end else begin
          check("scoreboard", 32'(out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete operation from IDLE. The latency check counts the edges
  // after the accept edge up to the first cycle in which done is high.
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] e);
    int n;
    in1 = a;
    in2 = b;
    start = 1'b1;
    exp_q.push_back(e);
    tick;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick;
      n++;
    end
    check("latency", 32'(n), 32'(W));
    check("product", 32'(out), 32'(e));
    tick;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc;
    int dc;
    int d1;
    int d2;
    bit got1;
    bit got2;
    int n;
    logic [2*W8-1:0] e8;

    rst = 1'b1;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    start8 = 1'b0;
    in1_8 = '0;
    in2_8 = '0;
    tick;
    chk_en = 1'b1;
    tick;
    tick;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_out",  32'(out),  32'(0));
    rst = 1'b0;
    tick;

`ifdef MULT_SIGNED_EN
    // Signed literals, then an exhaustive signed sweep.
    do_mult(4'h8, 4'h8, 8'h40);
    do_mult(4'h8, 4'h7, 8'hC8);
    do_mult(4'hF, 4'h1, 8'hFF);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        do_mult(4'(i), 4'(j), ref_prod(4'(i), 4'(j)));
`else
    // Unsigned literals, then an exhaustive unsigned sweep.
    do_mult(4'hF, 4'hF, 8'hE1);
    do_mult(4'h9, 4'h0, 8'h00);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        do_mult(4'(i), 4'(j), ref_prod(4'(i), 4'(j)));
`endif

    // Protocol: start and the operands change during CALC and must be ignored.
    in1 = 4'd3;
    in2 = 4'd2;
    start = 1'b1;
    exp_q.push_back(8'h06);
    tick;
    in1 = 4'd5;
    in2 = 4'd1;
    bc = 0;
    dc = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        start = 1'b0;
      end
      tick;
    end
    start = 1'b0;
    check("proto_busy_cycles", 32'(bc), 32'(5));
    check("proto_done_count",  32'(dc), 32'(1));
    check("proto_out",         32'(out), 32'h06);

    // Reset mid-operation: accept 7*6, then assert rst after two CALC edges.
    in1 = 4'd7;
    in2 = 4'd6;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_done", 32'(done), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_out",  32'(out),  32'(0));
    do_mult(4'd3, 4'd5, 8'h0F);

    // Back-to-back with start held high: 2*3, then 4*4.
    in1 = 4'd2;
    in2 = 4'd3;
    start = 1'b1;
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h10);
    tick;
    in1 = 4'd4;
    in2 = 4'd4;
    got1 = 1'b0;
    got2 = 1'b0;
    d1 = 0;
    d2 = 0;
    for (int k = 0; k < 30 && !got2; k++) begin
      if (done && !got1) begin
        got1 = 1'b1;
        d1 = cyc;
        check("b2b_first", 32'(out), 32'h06);
      end else if (done && got1) begin
        got2 = 1'b1;
        d2 = cyc;
        check("b2b_second", 32'(out), 32'h10);
        start = 1'b0;
      end else if (got1) begin
        check("b2b_hold", 32'(out), 32'h06);
      end
      tick;
    end
    start = 1'b0;
    check("b2b_second_seen", 32'(got2), 32'(1));
    check("b2b_spacing", 32'(d2 - d1), 32'(6));

    // WIDTH=8 corner case: 8'hFF * 8'hFF.
`ifdef MULT_SIGNED_EN
    e8 = 16'h0001;
`else
    e8 = 16'hFE01;
`endif
    in1_8 = 8'hFF;
    in2_8 = 8'hFF;
    start8 = 1'b1;
    tick;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin
      tick;
      n++;
    end
    check("w8_latency", 32'(n), 32'(W8));
    check("w8_product", 32'(out8), 32'(e8));
    tick;
    tick;

    chk_en = 1'b0;
    check("exp_q_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
